occ_fetch_server: RTL and testbench

Memory-side responder for the accelerator's Occ lookup port. Holds the 256×32 Occ table, loaded by the host before `is_start`. Turns the accelerator's `ce_rom_Occ_o`/`addr_rom_Occ_o` requests into `data_Occ_i`/`data_Occ_valid_i` responses after a fixed, parameterised latency that models the off-chip Occ memory. Sits directly downstream of `accelerator_top_1` and upstream of its Occ input.

---
 rtl/occ_fetch_server.sv | 175 +++++++++++++++++
 tb/tb_occ_fetch_server.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/occ_fetch_server.sv
// occ_fetch_server: memory-side responder for the accelerator's Occ lookup port.
// Holds a 256x32 Occ table written by the host. Each request event gets a
// one-cycle valid pulse with data LATENCY cycles later. There is a one-deep
// pending slot; when it is already full, the latest address wins.
// Optional feature: define OCC_HIT_BYPASS_EN to answer a repeat of the last
// responded address in one cycle.
module occ_fetch_server #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_rom_Occ_i,
  input  logic [7:0]  addr_rom_Occ_i,
  output logic [31:0] data_Occ_o,
  output logic        data_Occ_valid_o,
  input  logic        host_we_i,
  input  logic [7:0]  host_addr_i,
  input  logic [31:0] host_data_i,
  output logic        busy_o,
  output logic [15:0] req_count_o
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [31:0] mem_q [256];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  lat_addr_q, lat_addr_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  pend_addr_q, pend_addr_d;
  logic        prev_ce_q, prev_ce_d;
  logic [7:0]  prev_addr_q, prev_addr_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  logic        evt;
  logic        start;
  logic [7:0]  start_addr;
  logic        fast;
  logic [31:0] rd_data;

`ifdef OCC_HIT_BYPASS_EN
  logic        hit_vld_q, hit_vld_d;
  logic [7:0]  hit_addr_q, hit_addr_d;
`endif

  // A held ce with a stable address is a single request.
  assign evt = ce_rom_Occ_i & (~prev_ce_q | (addr_rom_Occ_i != prev_addr_q));

  // The response read sees a host write landing on the same edge.
  assign rd_data = (host_we_i && (host_addr_i == lat_addr_q)) ? host_data_i
                                                              : mem_q[lat_addr_q];

  // Table storage: host writes only, never reset.
  always_ff @(posedge clk) begin
    if (host_we_i) mem_q[host_addr_i] <= host_data_i;
  end

  // Next-state logic for the request FSM, the pending slot and the response registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_addr_d  = lat_addr_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    prev_ce_d   = ce_rom_Occ_i;
    prev_addr_d = addr_rom_Occ_i;
    data_d      = data_q;
    valid_d     = 1'b0;
    count_d     = count_q;
    start       = 1'b0;
    start_addr  = addr_rom_Occ_i;
    fast        = (LATENCY == 1);
`ifdef OCC_HIT_BYPASS_EN
    hit_vld_d   = hit_vld_q;
    hit_addr_d  = hit_addr_q;
    if (host_we_i && (host_addr_i == hit_addr_q)) hit_vld_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (evt) begin
          start = 1'b1;
`ifdef OCC_HIT_BYPASS_EN
          if (hit_vld_q && (addr_rom_Occ_i == hit_addr_q)) fast = 1'b1;
`endif
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
        if (evt) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = addr_rom_Occ_i;
        end
      end
      S_RESP: begin
        valid_d = 1'b1;
        data_d  = rd_data;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
`ifdef OCC_HIT_BYPASS_EN
        hit_vld_d  = 1'b1;
        hit_addr_d = lat_addr_q;
`endif
        // A same-edge event is newer than anything in the pending slot.
        if (evt) begin
          start      = 1'b1;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          start      = 1'b1;
          start_addr = pend_addr_q;
          pend_vld_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      lat_addr_d = start_addr;
      if (fast) begin
        state_d = S_RESP;
      end else begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
      end
    end
  end

  // State and output registers; a reset drops any in-flight or pending request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_addr_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      prev_ce_q   <= 1'b0;
      prev_addr_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      count_q     <= '0;
`ifdef OCC_HIT_BYPASS_EN
      hit_vld_q   <= 1'b0;
      hit_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_addr_q  <= lat_addr_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      prev_ce_q   <= prev_ce_d;
      prev_addr_q <= prev_addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
`ifdef OCC_HIT_BYPASS_EN
      hit_vld_q   <= hit_vld_d;
      hit_addr_q  <= hit_addr_d;
`endif
    end
  end

  assign data_Occ_o       = data_q;
  assign data_Occ_valid_o = valid_q;
  assign req_count_o      = count_q;
  assign busy_o           = (state_q != S_IDLE) | pend_vld_q;

endmodule

// File: tb/tb_occ_fetch_server.sv
// Directed bench for occ_fetch_server (LATENCY=2): table-driven single
// requests, then hand-written sequences for held ce, pending, latest-wins,
// same-cycle host write, reset mid-flight and the repeat-address path.
module tb_occ_fetch_server;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n, ce, host_we;
  logic [7:0]  addr, haddr;
  logic [31:0] hdata, data;
  logic        valid, busy;
  logic [15:0] cnt;

  occ_fetch_server #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ce_rom_Occ_i(ce), .addr_rom_Occ_i(addr),
    .data_Occ_o(data), .data_Occ_valid_o(valid),
    .host_we_i(host_we), .host_addr_i(haddr), .host_data_i(hdata),
    .busy_o(busy), .req_count_o(cnt)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge e (sampled at #1 or at the next negedge) it reads e.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse with the edge that produced it.
  int          vcyc[$];
  logic [31:0] vdat[$];
  always @(negedge clk) if (valid === 1'b1) begin
    vcyc.push_back(cyc);
    vdat.push_back(data);
  end

  int checks = 0, failures = 0, exp_cnt = 0;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hw(input logic [7:0] a, input logic [31:0] d);
    host_we = 1'b1; haddr = a; hdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic clrq();
    vcyc.delete(); vdat.delete();
  endtask

  // Check pulse number idx against an expected edge and data.
  task automatic chk_pulse(input string nm, input int idx, input int ecyc, input logic [31:0] edat);
    if (vcyc.size() > idx) begin
      chk({nm, "_cyc"}, vcyc[idx], ecyc);
      chk({nm, "_dat"}, vdat[idx], edat);
    end else begin
      checks++; failures++;
      $display("FAIL %s_missing actual=%0d pulses required>%0d", nm, vcyc.size(), idx);
    end
  endtask

  // One single-cycle request, returns the edge it is sampled on.
  task automatic req1(input logic [7:0] a, output int t);
    t = cyc + 1;
    ce = 1'b1; addr = a;
    tick();
    ce = 1'b0;
  endtask

  initial begin
    int t;
    vt[0] = '{8'h05, 32'hDEADBEEF};
    vt[1] = '{8'h06, 32'h0606_0606};
    vt[2] = '{8'h00, 32'h1234_5678};
    vt[3] = '{8'hFF, 32'hCAFE_F00D};

    rst_n = 1'b0; ce = 1'b0; addr = '0; host_we = 1'b0; haddr = '0; hdata = '0;
    tick(2);
    // Table loads during reset; the array is not under reset.
    for (int i = 0; i < 4; i++) hw(vt[i].a, vt[i].d);
    hw(8'h07, 32'h7777_7777);
    hw(8'h10, 32'h1010_1010);
    hw(8'h11, 32'h1111_1111);
    hw(8'h12, 32'h1212_1212);

    chk("rst_data",  data,  32'h0);
    chk("rst_valid", valid, 32'h0);
    chk("rst_busy",  busy,  32'h0);
    chk("rst_count", cnt,   32'h0);

    rst_n = 1'b1;
    tick(2);

    // Table-driven single requests.
    for (int i = 0; i < 4; i++) begin
      clrq();
      req1(vt[i].a, t);
      tick(LAT + 2);
      exp_cnt++;
      chk($sformatf("vec%0d_npulse", i), vcyc.size(), 1);
      chk_pulse($sformatf("vec%0d", i), 0, t + LAT, vt[i].d);
      chk($sformatf("vec%0d_count", i), cnt, exp_cnt);
    end

    // Held ce with stable address: one request only.
    clrq();
    t = cyc + 1; ce = 1'b1; addr = 8'h05;
    tick();
    chk("hold_busy", busy, 32'h1);
    tick(4);
    ce = 1'b0;
    tick(3);
    exp_cnt++;
    chk("hold_npulse", vcyc.size(), 1);
    chk_pulse("hold", 0, t + LAT, 32'hDEADBEEF);
    chk("hold_count", cnt, exp_cnt);

    // Address change while busy goes to pending.
    clrq();
    t = cyc + 1; ce = 1'b1; addr = 8'h05;
    tick();
    addr = 8'h06;
    tick(4);
    ce = 1'b0;
    tick(2);
    exp_cnt += 2;
    chk("pend_npulse", vcyc.size(), 2);
    chk_pulse("pend0", 0, t + LAT, 32'hDEADBEEF);
    chk_pulse("pend1", 1, t + 2 * LAT, 32'h0606_0606);
    chk("pend_count", cnt, exp_cnt);

    // Three changes in one busy window: in-flight, then latest only.
    clrq();
    t = cyc + 1; ce = 1'b1; addr = 8'h10;
    tick();
    addr = 8'h11;
    tick();
    addr = 8'h12;
    tick();
    ce = 1'b0;
    tick(5);
    exp_cnt += 2;
    chk("latest_npulse", vcyc.size(), 2);
    chk_pulse("latest0", 0, t + LAT, 32'h1010_1010);
    chk_pulse("latest1", 1, t + 2 * LAT, 32'h1212_1212);

    // Host write landing on the response edge is seen in the response.
    clrq();
    req1(8'h07, t);
    tick();
    hw(8'h07, 32'h0000_0001);
    tick(2);
    exp_cnt++;
    chk("wr_npulse", vcyc.size(), 1);
    chk_pulse("wr", 0, t + LAT, 32'h0000_0001);
    chk("wr_hold", data, 32'h0000_0001);
    chk("wr_count", cnt, exp_cnt);

    // Reset during WAIT drops the request.
    clrq();
    req1(8'h06, t);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    exp_cnt = 0;
    chk("rstmid_npulse", vcyc.size(), 0);
    chk("rstmid_data",   data,  32'h0);
    chk("rstmid_valid",  valid, 32'h0);
    chk("rstmid_busy",   busy,  32'h0);
    chk("rstmid_count",  cnt,   32'h0);
    clrq();
    req1(8'h05, t);
    tick(LAT + 2);
    exp_cnt++;
    chk_pulse("rstmid_tbl", 0, t + LAT, 32'hDEADBEEF);
    chk("rstmid_count2", cnt, exp_cnt);

    // Repeat of the last responded address.
    clrq();
    req1(8'h05, t);
    tick(LAT + 2);
    exp_cnt++;
`ifdef OCC_HIT_BYPASS_EN
    chk_pulse("repeat", 0, t + 1, 32'hDEADBEEF);
`else
    chk_pulse("repeat", 0, t + LAT, 32'hDEADBEEF);
`endif
    hw(8'h05, 32'hBEEF_0005);
    tick();
    clrq();
    req1(8'h05, t);
    tick(LAT + 2);
    exp_cnt++;
    chk_pulse("after_wr", 0, t + LAT, 32'hBEEF_0005);
    chk("repeat_count", cnt, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
